greedy_snake_move_ctrl: RTL and testbench
=========================================

Name: greedy_snake_move_ctrl

Overview:
Game-step sequencer for the snake body list held in the Gowin_DPB, driving channel A. On each step tick it computes the new head from the current direction and shifts the body list in BSRAM. It grows the list when the head lands on the fruit, publishes list_length/list_head_addr, and then handshakes one render pass with the channel-B map renderer (en/busy/game_over). Body entries occupy slots 0..len-1, with the tail at slot 0 and the head at slot len-1. Slot k is at address DATA_BEGIN_ADDRESS + k*ADDRESS_STEP_N. Entry format: [7:4]=x, [3:0]=y.

Parameters:
ADDRESS_STEP_N, 11'd4, address stride between slots
DATA_BEGIN_ADDRESS, 11'd4, address of slot 0
MAX_LEN, 11'd64, slot capacity; growth suppressed at this length
RD_WAIT, 4'd3, cycles from read address issue to a_dout sample
INIT_POS, 8'h77, head position written at reset
INIT_DIR, 2'd3, direction after reset (0 up, 1 down, 2 left, 3 right)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
step_tick  in  1  one-cycle game step request
dir_in  in  2  requested direction
dir_valid  in  1  dir_in strobe
point_pos  in  8  current fruit position
render_busy  in  1  renderer busy
render_game_over  in  1  renderer self-collision flag, valid when busy low
render_en  out  1  one-cycle render start pulse
a_clk_en  out  1  channel A clock enable, constant 1
a_ce  out  1  channel A data enable, constant 1
a_wr_en  out  1  channel A write enable
a_addr  out  11  channel A address
a_din  out  8  channel A write data
a_dout  in  8  channel A read data
list_length  out  11  body entry count
list_head_addr  out  11  head slot address
score  out  8  fruits eaten
ctrl_busy  out  1  high outside IDLE and OVER
game_over  out  1  sticky game over

Behaviour:
- Reset values:
  - list_length=1, list_head_addr=DATA_BEGIN_ADDRESS, score=0, game_over=0.
  - render_en=0, a_wr_en=0, a_addr=0, a_din=0, ctrl_busy=1.
  - cur_dir=INIT_DIR; pending tick cleared.
  - Next state is INIT.
- rst mid-operation aborts any shift or render wait immediately. There is no BSRAM cleanup; INIT rewrites slot 0.
- Direction:
  - On dir_valid, cur_dir<=dir_in, except when list_length>1 and dir_in is the exact reverse of cur_dir, in which case it is ignored.
  - dir_valid is accepted in any state.
  - The direction is applied at the next CALC.
- Tick buffering:
  - step_tick in IDLE starts a step.
  - step_tick in any other state except OVER sets a 1-deep pending flag; further ticks are dropped.
  - The pending flag is consumed on return to IDLE, starting the next step on the following cycle.
- States:
  - INIT: write INIT_POS to slot 0 (a_wr_en=1 for one cycle), then go to RENDER_REQ.
  - IDLE: wait for a tick or pending flag, then go to CALC.
  - CALC: compute new_head from the head value (held in a register, no BSRAM read).
    - up: y-1; down: y+1; left: x-1; right: x+1. Each 4-bit field wraps mod 16 (0xF5 right -> 0x05; 0x70 up -> 0x7F).
    - grow = (new_head==point_pos) && (list_length<MAX_LEN).
    - If grow, or list_length==1, go to HEAD_WR; otherwise i<=0 and go to SHIFT_RD.
  - SHIFT_RD: a_addr=slot(i+1), a_wr_en=0. Wait RD_WAIT cycles, latch a_dout, then go to SHIFT_WR.
  - SHIFT_WR: write the latched value to slot(i), then i<=i+1.
    - If i+1 == list_length-1, go to HEAD_WR; else go to SHIFT_RD.
  - HEAD_WR:
    - Write new_head to slot(list_length-1), or to slot(list_length) if grow.
    - If grow: list_length+1 and score+1; score saturates at 8'hFF.
    - list_head_addr updated in the same cycle; the head register <= new_head.
  - RENDER_REQ: render_en=1 for exactly one cycle, then go to RENDER_ACK.
  - RENDER_ACK: wait for render_busy=1, then go to RENDER_WAIT.
  - RENDER_WAIT: wait for render_busy=0.
    - If render_game_over=1: game_over<=1 and go to OVER.
    - Else go to IDLE.
  - OVER: absorbing until rst; ticks are ignored and there are no BSRAM writes.
- Invariants:
  - list_length and list_head_addr change only in HEAD_WR, never while render_busy=1.
  - a_wr_en is high only in INIT, SHIFT_WR and HEAD_WR.
- Step latency without growth, length L≥2: 1 (CALC) + (L-1)*(RD_WAIT+2) + 1 (HEAD_WR) cycles, then the render handshake.
- At MAX_LEN, a fruit hit behaves as a plain move: no growth and no score change.

Test Plan:
- Reset, renderer model acks in 2 cycles -> slot0 holds 0x77, one render_en pulse, list_length=1, list_head_addr=4, state reaches IDLE.
- Preload slots [0x11,0x21,0x31] with len=3, head=0x31, dir right, point_pos=0xAA; tick -> slots become [0x21,0x31,0x41], len=3, head_addr=12, score=0.
- Same preload, point_pos=0x41; tick -> slots [0x11,0x21,0x31,0x41], len=4, head_addr=16, score=1, no shift writes issued.
- head=0xF5 with dir right, then head=0x70 with dir up -> new heads 0x05 and 0x7F respectively.
- len=3, cur_dir right, dir_valid with dir_in=left, then tick -> left ignored, head moves right. Second tick during shift -> exactly one extra step; a third tick during the same step is dropped.
- Renderer returns render_game_over=1 at busy fall -> game_over=1, state OVER; further ticks give no writes and no render_en; rst restores INIT behaviour.

Source files
------------

// File: rtl/greedy_snake_move_ctrl.sv
// Snake step sequencer. Owns channel A of the body-list BSRAM: on each game step it
// computes the new head, shifts the body list one slot towards the tail (or appends on
// growth), publishes length/head address, then handshakes one render pass with the
// channel-B renderer. Slot k lives at DATA_BEGIN_ADDRESS + k*ADDRESS_STEP_N, tail at slot 0.
module greedy_snake_move_ctrl #(
  parameter logic [10:0] ADDRESS_STEP_N     = 11'd4,
  parameter logic [10:0] DATA_BEGIN_ADDRESS = 11'd4,
  parameter logic [10:0] MAX_LEN            = 11'd64,
  parameter logic [3:0]  RD_WAIT            = 4'd3,
  parameter logic [7:0]  INIT_POS           = 8'h77,
  parameter logic [1:0]  INIT_DIR           = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_tick,
  input  logic [1:0]  dir_in,
  input  logic        dir_valid,
  input  logic [7:0]  point_pos,
  input  logic        render_busy,
  input  logic        render_game_over,
  output logic        render_en,
  output logic        a_clk_en,
  output logic        a_ce,
  output logic        a_wr_en,
  output logic [10:0] a_addr,
  output logic [7:0]  a_din,
  input  logic [7:0]  a_dout,
  output logic [10:0] list_length,
  output logic [10:0] list_head_addr,
  output logic [7:0]  score,
  output logic        ctrl_busy,
  output logic        game_over
);

  typedef enum logic [3:0] {
    StInit,
    StIdle,
    StCalc,
    StShiftRd,
    StShiftWr,
    StHeadWr,
    StRenderReq,
    StRenderAck,
    StRenderWait,
    StOver
  } state_e;

  state_e state_q, state_d;

  // Datapath registers
  logic [1:0]  cur_dir_q;
  logic        pending_q;
  logic [7:0]  head_q;
  logic [7:0]  new_head_q;
  logic        grow_q;
  logic [10:0] idx_q;
  logic [3:0]  wait_q;
  logic [7:0]  rd_data_q;
  logic [10:0] len_q;
  logic [10:0] head_addr_q;
  logic [7:0]  score_q;
  logic        game_over_q;

  // Combinational helpers
  logic [3:0]  cur_x, cur_y, nxt_x, nxt_y;
  logic [7:0]  calc_head;
  logic        calc_grow;
  logic        rd_done;
  logic        last_shift;
  logic        dir_accept;

  function automatic logic [10:0] slot_addr(input logic [10:0] k);
    return DATA_BEGIN_ADDRESS + k * ADDRESS_STEP_N;
  endfunction

  // up<->down and left<->right differ only in bit 0
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // New head from the registered head and current direction; fields wrap mod 16
  always_comb begin
    cur_x = head_q[7:4];
    cur_y = head_q[3:0];
    nxt_x = cur_x;
    nxt_y = cur_y;
    unique case (cur_dir_q)
      2'd0:    nxt_y = cur_y - 4'd1;
      2'd1:    nxt_y = cur_y + 4'd1;
      2'd2:    nxt_x = cur_x - 4'd1;
      default: nxt_x = cur_x + 4'd1;
    endcase
    calc_head = {nxt_x, nxt_y};
    calc_grow = (calc_head == point_pos) && (len_q < MAX_LEN);
  end

  assign rd_done    = (wait_q == RD_WAIT);
  assign last_shift = ((idx_q + 11'd1) == (len_q - 11'd1));
  // A reversal would fold the head onto the neck, so it is refused once the body has a neck
  assign dir_accept = dir_valid && !((len_q > 11'd1) && (dir_in == reverse_dir(cur_dir_q)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:      state_d = StRenderReq;
      StIdle:      if (step_tick || pending_q) state_d = StCalc;
      StCalc:      state_d = (calc_grow || (len_q == 11'd1)) ? StHeadWr : StShiftRd;
      StShiftRd:   if (rd_done) state_d = StShiftWr;
      StShiftWr:   state_d = last_shift ? StHeadWr : StShiftRd;
      StHeadWr:    state_d = StRenderReq;
      StRenderReq: state_d = StRenderAck;
      StRenderAck: if (render_busy) state_d = StRenderWait;
      StRenderWait: begin
        if (!render_busy) state_d = render_game_over ? StOver : StIdle;
      end
      StOver:      state_d = StOver;
      default:     state_d = StInit;
    endcase
  end

  // Datapath: direction, tick buffering, shift bookkeeping and published list state
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_dir_q   <= INIT_DIR;
      pending_q   <= 1'b0;
      head_q      <= INIT_POS;
      new_head_q  <= 8'h00;
      grow_q      <= 1'b0;
      idx_q       <= 11'd0;
      wait_q      <= 4'd0;
      rd_data_q   <= 8'h00;
      len_q       <= 11'd1;
      head_addr_q <= DATA_BEGIN_ADDRESS;
      score_q     <= 8'h00;
      game_over_q <= 1'b0;
    end else begin
      if (dir_accept) cur_dir_q <= dir_in;

      // IDLE consumes the flag (or a direct tick); elsewhere one tick is remembered
      if (state_q == StIdle) begin
        pending_q <= 1'b0;
      end else if (step_tick && (state_q != StOver)) begin
        pending_q <= 1'b1;
      end

      unique case (state_q)
        StCalc: begin
          new_head_q <= calc_head;
          grow_q     <= calc_grow;
          idx_q      <= 11'd0;
          wait_q     <= 4'd0;
        end
        StShiftRd: begin
          if (rd_done) begin
            rd_data_q <= a_dout;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        StShiftWr: begin
          idx_q  <= idx_q + 11'd1;
          wait_q <= 4'd0;
        end
        StHeadWr: begin
          head_q <= new_head_q;
          if (grow_q) begin
            len_q       <= len_q + 11'd1;
            head_addr_q <= slot_addr(len_q);
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
          end
        end
        StRenderWait: begin
          if (!render_busy && render_game_over) game_over_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Channel A and render strobe; held quiet while reset is asserted
  always_comb begin
    a_wr_en   = 1'b0;
    a_addr    = 11'd0;
    a_din     = 8'h00;
    render_en = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StInit: begin
          a_wr_en = 1'b1;
          a_addr  = DATA_BEGIN_ADDRESS;
          a_din   = INIT_POS;
        end
        StShiftRd: begin
          a_addr = slot_addr(idx_q + 11'd1);
        end
        StShiftWr: begin
          a_wr_en = 1'b1;
          a_addr  = slot_addr(idx_q);
          a_din   = rd_data_q;
        end
        StHeadWr: begin
          a_wr_en = 1'b1;
          a_addr  = grow_q ? slot_addr(len_q) : slot_addr(len_q - 11'd1);
          a_din   = new_head_q;
        end
        StRenderReq: begin
          render_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a_clk_en       = 1'b1;
  assign a_ce           = 1'b1;
  assign list_length    = len_q;
  assign list_head_addr = head_addr_q;
  assign score          = score_q;
  assign game_over      = game_over_q;
  assign ctrl_busy      = !((state_q == StIdle) || (state_q == StOver));

endmodule

// File: tb/tb_greedy_snake_move_ctrl.sv
// Bench for greedy_snake_move_ctrl: BSRAM and renderer models plus a list-level snake model.
module tb_greedy_snake_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_tick = 1'b0;
  logic [1:0]  dir_in = 2'd0;
  logic        dir_valid = 1'b0;
  logic [7:0]  point_pos = 8'hEE;
  logic        render_busy = 1'b0;
  logic        render_game_over = 1'b0;
  logic        render_en, a_clk_en, a_ce, a_wr_en, ctrl_busy, game_over;
  logic [10:0] a_addr, list_length, list_head_addr;
  logic [7:0]  a_din, a_dout, score;

  always #5 clk = ~clk;

  greedy_snake_move_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .step_tick        (step_tick),
    .dir_in           (dir_in),
    .dir_valid        (dir_valid),
    .point_pos        (point_pos),
    .render_busy      (render_busy),
    .render_game_over (render_game_over),
    .render_en        (render_en),
    .a_clk_en         (a_clk_en),
    .a_ce             (a_ce),
    .a_wr_en          (a_wr_en),
    .a_addr           (a_addr),
    .a_din            (a_din),
    .a_dout           (a_dout),
    .list_length      (list_length),
    .list_head_addr   (list_head_addr),
    .score            (score),
    .ctrl_busy        (ctrl_busy),
    .game_over        (game_over)
  );

  // BSRAM channel A: registered read, one-cycle latency
  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (a_wr_en) mem[a_addr] <= a_din;
    a_dout <= mem[a_addr];
  end

  // Renderer: busy rises 2 cycles after render_en, falls 3 cycles later with the verdict
  logic go_next = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (render_en && !rst) begin
        repeat (2) @(negedge clk);
        render_busy      = 1'b1;
        render_game_over = 1'b0;
        repeat (3) @(negedge clk);
        render_game_over = go_next;
        render_busy      = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- list-level model ----------------
  typedef struct packed {
    logic [10:0]      len;
    logic [10:0]      haddr;
    logic [7:0]       score;
    logic [10:0]      writes;
    logic [63:0][7:0] body;
  } snap_t;

  logic [7:0] body_q[$];
  logic [1:0] m_dir;
  int         m_score;
  snap_t      exp_q[$];

  function automatic int slot(input int k);
    return 4 + 4 * k;
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] d);
    case (d)
      2'd0: return 2'd1;
      2'd1: return 2'd0;
      2'd2: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] next_head(input logic [7:0] h, input logic [1:0] d);
    logic [3:0] x, y;
    x = h[7:4];
    y = h[3:0];
    case (d)
      2'd0: y = y - 4'd1;
      2'd1: y = y + 4'd1;
      2'd2: x = x - 4'd1;
      default: x = x + 4'd1;
    endcase
    return {x, y};
  endfunction

  function automatic snap_t make_snap(input int writes);
    snap_t s;
    s        = '0;
    s.len    = 11'(body_q.size());
    s.haddr  = 11'(slot(body_q.size() - 1));
    s.score  = 8'(m_score);
    s.writes = 11'(writes);
    for (int k = 0; k < body_q.size(); k++) s.body[k] = body_q[k];
    return s;
  endfunction

  task automatic model_reset();
    body_q.delete();
    body_q.push_back(8'h77);
    m_dir   = 2'd3;
    m_score = 0;
    exp_q.delete();
    exp_q.push_back(make_snap(1));
  endtask

  task automatic model_step(input logic [7:0] pt);
    logic [7:0] nh;
    bit         grow;
    int         writes;
    nh     = next_head(body_q[$], m_dir);
    grow   = (nh == pt) && (body_q.size() < 64);
    writes = (grow || body_q.size() == 1) ? 1 : body_q.size();
    body_q.push_back(nh);
    if (!grow) void'(body_q.pop_front());
    else if (m_score < 255) m_score++;
    exp_q.push_back(make_snap(writes));
  endtask

  // ---------------- compare process ----------------
  int          wr_cnt = 0;
  int          total_wr = 0;
  int          render_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [10:0] prev_len = '0;
  logic [10:0] prev_haddr = '0;
  snap_t       cs;
  bit          body_ok;

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt    = 0;
      prev_busy = 1'b0;
    end else begin
      if (a_wr_en) begin
        wr_cnt++;
        total_wr++;
      end
      if (render_busy && prev_busy) begin
        check("len_stable_busy", list_length, prev_len);
        check("haddr_stable_busy", list_head_addr, prev_haddr);
      end
      if (render_en) begin
        render_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_render", 1, 0);
        end else begin
          cs = exp_q.pop_front();
          check("list_length", list_length, cs.len);
          check("list_head_addr", list_head_addr, cs.haddr);
          check("score", score, cs.score);
          check("step_writes", wr_cnt, cs.writes);
          body_ok = 1'b1;
          for (int k = 0; k < int'(cs.len); k++)
            if (mem[slot(k)] !== cs.body[k]) body_ok = 1'b0;
          check("body_slots", body_ok, 1);
        end
        wr_cnt = 0;
      end
      prev_busy  = render_busy;
      prev_len   = list_length;
      prev_haddr = list_head_addr;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ctrl_busy || exp_q.size() != 0) && n < 3000);
    check("reach_idle_timeout", (n >= 3000), 0);
  endtask

  task automatic step();
    model_step(point_pos);
    tick();
    wait_idle();
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(negedge clk);
    dir_in    = d;
    dir_valid = 1'b1;
    if (!(body_q.size() > 1 && d == rev(m_dir))) m_dir = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
  endtask

  int lat, r0, w0;

  initial begin
    // Reset values while rst is held
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_a_wr_en", a_wr_en, 0);
    check("rst_a_addr", a_addr, 0);
    check("rst_a_din", a_din, 0);
    check("rst_render_en", render_en, 0);
    check("rst_ctrl_busy", ctrl_busy, 1);
    check("rst_list_length", list_length, 1);
    check("rst_head_addr", list_head_addr, 4);
    check("rst_score", score, 0);
    check("rst_game_over", game_over, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    check("init_slot0", mem[4], 8'h77);
    check("init_render_pulses", render_cnt, 1);
    check("init_idle", ctrl_busy, 0);

    // Grow to [77,87,97]
    point_pos = 8'h87;
    step();
    point_pos = 8'h97;
    step();
    check("grow2_len", list_length, 3);
    check("grow2_score", score, 2);

    // Plain move at length 3, with latency measurement
    point_pos = 8'hEE;
    model_step(point_pos);
    @(negedge clk);
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
    lat = 1;
    while (!render_en && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("move_latency", lat, 13);
    wait_idle();
    check("move_slot0", mem[4], 8'h87);
    check("move_slot1", mem[8], 8'h97);
    check("move_slot2", mem[12], 8'hA7);
    check("move_head_addr", list_head_addr, 12);
    check("move_score", score, 2);

    // Fruit hit appends without shifting
    point_pos = 8'hB7;
    step();
    check("eat_len", list_length, 4);
    check("eat_head_addr", list_head_addr, 16);
    check("eat_score", score, 3);
    check("eat_slot0", mem[4], 8'h87);
    check("eat_slot3", mem[16], 8'hB7);

    // x wraps F -> 0
    point_pos = 8'hEE;
    repeat (5) step();
    check("wrap_x_head", mem[16], 8'h07);
    check("wrap_x_prev", mem[12], 8'hF7);

    // y wraps 0 -> F going up
    set_dir(2'd0);
    repeat (8) step();
    check("wrap_y_head", mem[16], 8'h0F);

    // Reversals ignored with a neck present
    set_dir(2'd1);
    step();
    check("rev_down_ignored", mem[16], 8'h0E);
    set_dir(2'd3);
    step();
    check("turn_right", mem[16], 8'h1E);
    set_dir(2'd2);
    step();
    check("rev_left_ignored", mem[16], 8'h2E);

    // Tick buffering: one pending step, third tick dropped
    r0 = render_cnt;
    model_step(point_pos);
    model_step(point_pos);
    tick();
    repeat (4) @(negedge clk);
    tick();
    repeat (3) @(negedge clk);
    tick();
    wait_idle();
    repeat (40) @(negedge clk);
    check("pending_renders", render_cnt - r0, 2);
    check("pending_head", mem[16], 8'h4E);

    // Game over from renderer
    go_next = 1'b1;
    step();
    go_next = 1'b0;
    check("over_flag", game_over, 1);
    check("over_not_busy", ctrl_busy, 0);
    r0 = render_cnt;
    w0 = total_wr;
    repeat (3) begin
      tick();
      repeat (10) @(negedge clk);
    end
    check("over_no_render", render_cnt - r0, 0);
    check("over_no_writes", total_wr - w0, 0);
    check("over_sticky", game_over, 1);

    // Reset restores INIT behaviour
    render_game_over = 1'b0;
    do_reset();
    check("reinit_game_over", game_over, 0);
    check("reinit_slot0", mem[4], 8'h77);
    check("reinit_len", list_length, 1);
    check("reinit_score", score, 0);

    // Fill to MAX_LEN, then a fruit hit must act as a plain move
    for (int i = 0; i < 63; i++) begin
      point_pos = next_head(body_q[$], 2'd3);
      step();
    end
    check("full_len", list_length, 64);
    check("full_head_addr", list_head_addr, 256);
    check("full_score", score, 63);
    point_pos = next_head(body_q[$], 2'd3);
    step();
    check("max_len_hold", list_length, 64);
    check("max_score_hold", score, 63);
    check("max_head", mem[256], 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
